// File: rtl/sevenseg_scan_pkg.sv
// sevenseg_scan_pkg: shared state encodings and sizing helpers for the 7-segment scan controller.
// Revision: 1.0
`default_nettype none

package sevenseg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sevenseg_scan_timer.sv
// sevenseg_scan_timer: per-phase cycle counter and digit index for the scan controller.
// Revision: 1.0
`default_nettype none

module sevenseg_scan_timer
  import sevenseg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 8,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  state_e                              state_q,
  output logic [cnt_width(NUM_DIGITS)-1:0]    idx,
  output logic                                phase_end,
  output logic                                frame_end
);

  localparam int CNT_W = cnt_width(max_int(DWELL_CYCLES, BLANK_CYCLES));
  localparam int IDX_W = cnt_width(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             show_last;
  logic             blank_last;

  always_comb begin
    show_last  = (state_q == ST_SHOW)  && (cnt_q == DWELL_LAST);
    blank_last = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
    phase_end  = show_last || blank_last;
    frame_end  = show_last && (idx_q == IDX_LAST);

    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!enable || (state_q == ST_IDLE)) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (phase_end) begin
      cnt_d = '0;
      if (state_q == ST_SHOW) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed 7-segment scan with a frame-atomic load handshake.
// Optional LEADING_ZERO_BLANK_EN darkens digits above the highest nonzero nibble. Revision: 1.0
`default_nettype none

module sevenseg_scan_ctrl
  import sevenseg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 8,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [3:0]              dec_x,
  input  logic [6:0]              dec_z,
  output logic [6:0]              seg_z,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int DATA_W    = 4 * NUM_DIGITS;
  localparam int IDX_W     = cnt_width(NUM_DIGITS);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic [DATA_W-1:0] pending_q, pending_d;
  logic              pend_v_q, pend_v_d;

  logic [IDX_W-1:0]  idx;
  logic              phase_end;
  logic              frame_end;
  logic              xfer;
  logic              commit;
  logic              show;
  logic              lz_blank;

  sevenseg_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .DWELL_CYCLES (DWELL_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .state_q   (state_q),
    .idx       (idx),
    .phase_end (phase_end),
    .frame_end (frame_end)
  );

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = HAS_BLANK ? ST_BLANK : ST_SHOW;
        ST_BLANK: if (phase_end) state_d = ST_SHOW;
        ST_SHOW:  if (phase_end) state_d = HAS_BLANK ? ST_BLANK : ST_SHOW;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // New values only reach the display between frames (or while dark), so a frame is never torn.
  always_comb begin
    xfer   = load_valid && !pend_v_q;
    commit = pend_v_q && (frame_end || (state_q == ST_IDLE));

    pending_d = xfer ? load_data : pending_q;
    active_d  = commit ? pending_q : active_q;
    pend_v_d  = pend_v_q;
    if (xfer) begin
      pend_v_d = 1'b1;
    end else if (commit) begin
      pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      active_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] hi_idx;

  always_comb begin
    hi_idx = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (active_q[i*4 +: 4] != 4'h0) begin
        hi_idx = IDX_W'(i);
      end
    end
    lz_blank = (idx > hi_idx);
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    show  = (state_q == ST_SHOW);
    dec_x = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_sel[i] = show && (idx == IDX_W'(i));
      if (idx == IDX_W'(i)) begin
        dec_x = active_q[i*4 +: 4];
      end
    end
    seg_z = (show && !lz_blank) ? dec_z : SEG_OFF;
  end

  assign load_ready = !pend_v_q;
  assign frame_done = frame_end;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed, table-driven checks of the scan controller with a bench-side decoder.
// Revision: 1.0
`default_nettype none

module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic        load_ready;
  logic [3:0]  dec_x;
  logic [6:0]  dec_z;
  logic [6:0]  seg_z;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;
  int ph     = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] x);
    case (x)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  assign dec_z = seg7(dec_x);

  sevenseg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .dec_x      (dec_x),
    .dec_z      (dec_z),
    .seg_z      (seg_z),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [6:0] seg;
    logic [3:0] sel;
    logic       fd;
  } vec_t;

  vec_t tbl [40];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (phase %0d, t=%0t)", name, act, exp, ph, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 20;
  endtask

  task automatic adv_to(input int p);
    for (int n = 0; n < 20 && ph != p; n++) step();
  endtask

  task automatic chk_dark(input string name);
    chk({name, "_sel"}, 32'(digit_sel), 32'h0);
    chk({name, "_seg"}, 32'(seg_z), 32'h0);
  endtask

  initial begin
    int acc [5];
    int f;
    int nxt;
    logic take;

    // Expected outputs for two frames of 16'h3210 (blank, then 4 dwell cycles per digit).
    for (int k = 0; k < 40; k++) begin
      int p, d, s;
      logic [15:0] v;
      v = 16'h3210;
      p = k % 20; d = p / 5; s = p % 5;
      tbl[k].en  = 1'b1;
      tbl[k].seg = (s == 0) ? 7'h00 : seg7(v[d*4 +: 4]);
      tbl[k].sel = (s == 0) ? 4'h0 : 4'(1 << d);
      tbl[k].fd  = (d == 3) && (s == 4);
    end

    // 1. Reset with enable high
    enable = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_seg", 32'(seg_z), 32'h0);
    chk("rst_sel", 32'(digit_sel), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_decx", 32'(dec_x), 32'h0);
    step(); step();
    chk_dark("rst_hold");
    enable = 1'b0;
    rst = 1'b0;
    step();

    // 2. Basic scan
    load_valid = 1'b1; load_data = 16'h3210;
    step();
    chk("load_ready_drop", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    enable = 1'b1;
    step();
    ph = 0;
    chk("idle_commit_ready", 32'(load_ready), 32'h1);
    for (int k = 0; k < 40; k++) begin
      enable = tbl[k].en;
      chk($sformatf("scan%0d_seg", k), 32'(seg_z), 32'(tbl[k].seg));
      chk($sformatf("scan%0d_sel", k), 32'(digit_sel), 32'(tbl[k].sel));
      chk($sformatf("scan%0d_fd", k), 32'(frame_done), 32'(tbl[k].fd));
      step();
    end

    // 3. Load mid-frame during digit 1
    adv_to(6);
    load_valid = 1'b1; load_data = 16'hABCD;
    step();
    chk("mid_ready_low", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    adv_to(11);
    chk("mid_d2_seg", 32'(seg_z), 32'(seg7(4'h2)));
    chk("mid_d2_sel", 32'(digit_sel), 32'h4);
    adv_to(16);
    chk("mid_d3_seg", 32'(seg_z), 32'(seg7(4'h3)));
    adv_to(19);
    chk("mid_fd", 32'(frame_done), 32'h1);
    chk("mid_ready_still_low", 32'(load_ready), 32'h0);
    step();
    chk("mid_ready_back", 32'(load_ready), 32'h1);
    step();
    chk("new_d0_seg", 32'(seg_z), 32'h3D);
    chk("new_d0_sel", 32'(digit_sel), 32'h1);
    adv_to(6);
    chk("new_d1_seg", 32'(seg_z), 32'(seg7(4'hC)));

    // 4. Enable drop during digit 2
    adv_to(12);
    enable = 1'b0;
    step();
    chk_dark("endrop");
    chk("endrop_fd", 32'(frame_done), 32'h0);
    step();
    chk_dark("endrop_hold");
    enable = 1'b1;
    step();
    ph = 0;
    chk_dark("reen_blank");
    step();
    chk("reen_sel", 32'(digit_sel), 32'h1);
    chk("reen_seg", 32'(seg_z), 32'(seg7(4'hD)));

    // 5. Leading-zero blanking
    load_valid = 1'b1; load_data = 16'h0050;
    step();
    load_valid = 1'b0;
    adv_to(0);
    step();
    chk("lz50_d0", 32'(seg_z), 32'h7E);
    adv_to(6);
    chk("lz50_d1", 32'(seg_z), 32'h5B);
    adv_to(11);
    chk("lz50_d2", 32'(seg_z), LZ ? 32'h0 : 32'h7E);
    chk("lz50_d2_sel", 32'(digit_sel), 32'h4);
    adv_to(16);
    chk("lz50_d3", 32'(seg_z), LZ ? 32'h0 : 32'h7E);
    chk("lz50_d3_sel", 32'(digit_sel), 32'h8);
    load_valid = 1'b1; load_data = 16'h0000;
    step();
    load_valid = 1'b0;
    adv_to(0);
    step();
    chk("lz0_d0", 32'(seg_z), 32'h7E);
    adv_to(6);
    chk("lz0_d1", 32'(seg_z), LZ ? 32'h0 : 32'h7E);
    adv_to(16);
    chk("lz0_d3", 32'(seg_z), LZ ? 32'h0 : 32'h7E);
    chk("lz0_d3_sel", 32'(digit_sel), 32'h8);

    // 6. Back-to-back loads with load_valid held
    adv_to(1);
    for (int i = 0; i < 5; i++) acc[i] = 0;
    f = 0; nxt = 1;
    load_valid = 1'b1; load_data = 16'h1111;
    for (int n = 0; n < 80; n++) begin
      take = load_valid && load_ready;
      step();
      if (take) begin
        acc[f]++;
        nxt++;
        if (nxt <= 3) load_data = 16'(nxt * 16'h1111);
        else          load_valid = 1'b0;
      end
      if (ph == 0) f++;
      if (ph == 6 && f >= 1 && f <= 3)
        chk($sformatf("b2b_f%0d_d1", f), 32'(seg_z), 32'(seg7(4'(f))));
      if (ph == 16 && f >= 1 && f <= 3)
        chk($sformatf("b2b_f%0d_d3", f), 32'(seg_z), 32'(seg7(4'(f))));
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b_accepts_f%0d", i), 32'(acc[i]), (i < 3) ? 32'h1 : 32'h0);

    // Asynchronous reset mid-cycle loses pending and active
    load_valid = 1'b1; load_data = 16'h9999;
    step();
    load_valid = 1'b0;
    chk("pre_rst_ready", 32'(load_ready), 32'h0);
    #3 rst = 1'b1;
    #1;
    chk_dark("async_rst");
    chk("async_rst_ready", 32'(load_ready), 32'h1);
    chk("async_rst_fd", 32'(frame_done), 32'h0);
    chk("async_rst_decx", 32'(dec_x), 32'h0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
